// File: rtl/bp_update_queue_if.sv
// Commit-side and predictor-side signals of the branch update queue.
// The slave modport is the queue itself; the master modport is the
// surrounding commit/predictor logic (or a testbench).
interface bp_update_queue_if #(
  parameter int unsigned SIZE_PC   = 32,
  parameter int unsigned DEPTH_LOG = 3
);
  logic               commitEn0_i;
  logic [SIZE_PC-1:0] commitPC0_i;
  logic               commitDir0_i;
  logic               commitEn1_i;
  logic [SIZE_PC-1:0] commitPC1_i;
  logic               commitDir1_i;
  logic               updateHold_i;
  logic               updateEn_o;
  logic [SIZE_PC-1:0] updatePC_o;
  logic               updateDir_o;
  logic               full_o;
  logic [DEPTH_LOG:0] count_o;
  logic               overflow_o;

  modport master (
    output commitEn0_i, commitPC0_i, commitDir0_i,
    output commitEn1_i, commitPC1_i, commitDir1_i,
    output updateHold_i,
    input  updateEn_o, updatePC_o, updateDir_o,
    input  full_o, count_o, overflow_o
  );

  modport slave (
    input  commitEn0_i, commitPC0_i, commitDir0_i,
    input  commitEn1_i, commitPC1_i, commitDir1_i,
    input  updateHold_i,
    output updateEn_o, updatePC_o, updateDir_o,
    output full_o, count_o, overflow_o
  );
endinterface

// File: rtl/bp_update_queue.sv
// Branch predictor update queue: buffers up to two retired conditional
// branches per cycle and drains them one per cycle, in retirement order,
// into the predictor's single registered update port.
module bp_update_queue #(
  parameter int unsigned SIZE_PC   = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DEPTH_LOG = 3
) (
  input logic             clk,
  input logic             reset,
  bp_update_queue_if.slave bus
);

  // Full one entry early so a dual enqueue always fits, whatever the dequeue does.
  localparam logic [DEPTH_LOG:0] FullLevel = (DEPTH_LOG + 1)'(DEPTH - 1);

  logic [SIZE_PC-1:0]   pc_mem [DEPTH];
  logic [DEPTH-1:0]     dir_mem;

  logic [DEPTH_LOG-1:0] head_q, head_d;
  logic [DEPTH_LOG-1:0] tail_q, tail_d;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 upd_en_q;
  logic [SIZE_PC-1:0]   upd_pc_q;
  logic                 upd_dir_q;

  logic                 full;
  logic                 wr0, wr1;
  logic [DEPTH_LOG-1:0] wr1_idx;
  logic [1:0]           n_enq;
  logic                 deq;

  // Enqueue/dequeue decisions and next-state pointers and occupancy.
  always_comb begin
    full       = (count_q >= FullLevel);
    wr0        = !full && bus.commitEn0_i;
    wr1        = !full && bus.commitEn1_i;
    // Slot 1 is younger, so it lands after slot 0 when both are valid.
    wr1_idx    = wr0 ? tail_q + DEPTH_LOG'(1) : tail_q;
    n_enq      = {1'b0, wr0} + {1'b0, wr1};
    // Eligibility uses the pre-enqueue count: no enqueue-to-dequeue bypass.
    deq        = (count_q != '0) && !bus.updateHold_i;
    tail_d     = tail_q + DEPTH_LOG'(n_enq);
    head_d     = deq ? head_q + DEPTH_LOG'(1) : head_q;
    count_d    = count_q + (DEPTH_LOG + 1)'(n_enq) - (DEPTH_LOG + 1)'(deq);
    overflow_d = overflow_q || (full && (bus.commitEn0_i || bus.commitEn1_i));
  end

  // Entry storage; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr0) begin
      pc_mem[tail_q]  <= bus.commitPC0_i;
      dir_mem[tail_q] <= bus.commitDir0_i;
    end
    if (wr1) begin
      pc_mem[wr1_idx]  <= bus.commitPC1_i;
      dir_mem[wr1_idx] <= bus.commitDir1_i;
    end
  end

  // Pointers, occupancy, sticky overflow and the registered update port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      upd_en_q   <= 1'b0;
      upd_pc_q   <= '0;
      upd_dir_q  <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      upd_en_q   <= deq;
      if (deq) begin
        upd_pc_q  <= pc_mem[head_q];
        upd_dir_q <= dir_mem[head_q];
      end
    end
  end

  assign bus.updateEn_o  = upd_en_q;
  assign bus.updatePC_o  = upd_pc_q;
  assign bus.updateDir_o = upd_dir_q;
  assign bus.full_o      = full;
  assign bus.count_o     = count_q;
  assign bus.overflow_o  = overflow_q;

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed testbench for bp_update_queue. Inputs change and outputs are
// checked on the falling edge; the design updates on the rising edge.
module tb_bp_update_queue;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  bp_update_queue_if #(.SIZE_PC(32), .DEPTH_LOG(3)) bus ();

  bp_update_queue #(
    .SIZE_PC  (32),
    .DEPTH    (8),
    .DEPTH_LOG(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return at the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_commits();
    bus.commitEn0_i  = 1'b0;
    bus.commitPC0_i  = '0;
    bus.commitDir0_i = 1'b0;
    bus.commitEn1_i  = 1'b0;
    bus.commitPC1_i  = '0;
    bus.commitDir1_i = 1'b0;
  endtask

  task automatic commit2(input logic [31:0] pc0, input logic d0,
                         input logic [31:0] pc1, input logic d1);
    bus.commitEn0_i  = 1'b1;
    bus.commitPC0_i  = pc0;
    bus.commitDir0_i = d0;
    bus.commitEn1_i  = 1'b1;
    bus.commitPC1_i  = pc1;
    bus.commitDir1_i = d1;
  endtask

  task automatic chk_strobe(input string tag, input logic [31:0] pc, input logic dir);
    chk({tag, ".en"}, 64'(bus.updateEn_o), 64'd1);
    chk({tag, ".pc"}, 64'(bus.updatePC_o), 64'(pc));
    chk({tag, ".dir"}, 64'(bus.updateDir_o), 64'(dir));
  endtask

  logic [31:0] exp_pc [8];
  logic        exp_dir [8];

  initial begin
    total = 0;
    bad   = 0;
    idle_commits();
    bus.updateHold_i = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst.en", 64'(bus.updateEn_o), 64'd0);
    chk("rst.pc", 64'(bus.updatePC_o), 64'd0);
    chk("rst.dir", 64'(bus.updateDir_o), 64'd0);
    chk("rst.count", 64'(bus.count_o), 64'd0);
    chk("rst.full", 64'(bus.full_o), 64'd0);
    chk("rst.ovf", 64'(bus.overflow_o), 64'd0);
    reset = 1'b0;

    // Single commit: strobe two cycles after the commit cycle, for one cycle
    bus.commitEn0_i  = 1'b1;
    bus.commitPC0_i  = 32'h1000;
    bus.commitDir0_i = 1'b1;
    cyc();
    idle_commits();
    chk("single.count1", 64'(bus.count_o), 64'd1);
    chk("single.noen", 64'(bus.updateEn_o), 64'd0);
    cyc();
    chk_strobe("single.s", 32'h1000, 1'b1);
    chk("single.count0", 64'(bus.count_o), 64'd0);
    cyc();
    chk("single.en_off", 64'(bus.updateEn_o), 64'd0);

    // Dual commit leaves in age order
    commit2(32'h2000, 1'b0, 32'h2004, 1'b1);
    cyc();
    idle_commits();
    chk("dual.count2", 64'(bus.count_o), 64'd2);
    cyc();
    chk_strobe("dual.s0", 32'h2000, 1'b0);
    cyc();
    chk_strobe("dual.s1", 32'h2004, 1'b1);
    chk("dual.count0", 64'(bus.count_o), 64'd0);
    cyc();
    chk("dual.en_off", 64'(bus.updateEn_o), 64'd0);

    // Slot 1 alone
    bus.commitEn1_i  = 1'b1;
    bus.commitPC1_i  = 32'h3000;
    bus.commitDir1_i = 1'b1;
    cyc();
    idle_commits();
    chk("slot1.count1", 64'(bus.count_o), 64'd1);
    cyc();
    chk_strobe("slot1.s", 32'h3000, 1'b1);
    cyc();
    chk("slot1.en_off", 64'(bus.updateEn_o), 64'd0);
    chk("slot1.count0", 64'(bus.count_o), 64'd0);

    // Fill under hold: 0,2,4,6 are not full; 8 is full (threshold is 7)
    bus.updateHold_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_pc[2*k]    = 32'h4000 + 32'(8 * k);
      exp_dir[2*k]   = k[0];
      exp_pc[2*k+1]  = 32'h4004 + 32'(8 * k);
      exp_dir[2*k+1] = ~k[0];
      commit2(exp_pc[2*k], exp_dir[2*k], exp_pc[2*k+1], exp_dir[2*k+1]);
      cyc();
      chk($sformatf("fill.count%0d", k), 64'(bus.count_o), 64'(2 * (k + 1)));
      chk($sformatf("fill.full%0d", k), 64'(bus.full_o), (k == 3) ? 64'd1 : 64'd0);
      chk($sformatf("fill.noen%0d", k), 64'(bus.updateEn_o), 64'd0);
    end
    chk("fill.ovf_clear", 64'(bus.overflow_o), 64'd0);
    // Attempt while full is dropped and sets overflow
    commit2(32'hDEAD0000, 1'b1, 32'hDEAD0004, 1'b0);
    cyc();
    idle_commits();
    chk("ovf.set", 64'(bus.overflow_o), 64'd1);
    chk("ovf.count", 64'(bus.count_o), 64'd8);
    cyc();
    chk("ovf.sticky", 64'(bus.overflow_o), 64'd1);
    chk("ovf.held", 64'(bus.updateEn_o), 64'd0);
    bus.updateHold_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk_strobe($sformatf("drain%0d", i), exp_pc[i], exp_dir[i]);
      chk($sformatf("drain%0d.count", i), 64'(bus.count_o), 64'(7 - i));
    end
    cyc();
    chk("drain.en_off", 64'(bus.updateEn_o), 64'd0);
    chk("drain.count0", 64'(bus.count_o), 64'd0);

    // Advance pointers from 4 to 7 with three single commits
    for (int i = 0; i < 3; i++) begin
      bus.commitEn0_i  = 1'b1;
      bus.commitPC0_i  = 32'h5000 + 32'(4 * i);
      bus.commitDir0_i = 1'(i);
      cyc();
      if (i > 0) chk_strobe($sformatf("adv%0d", i - 1), 32'h5000 + 32'(4 * (i - 1)), 1'(i - 1));
    end
    idle_commits();
    cyc();
    chk_strobe("adv2", 32'h5008, 1'b0);
    cyc();
    chk("adv.tail7", 64'(dut.tail_q), 64'd7);
    chk("adv.head7", 64'(dut.head_q), 64'd7);

    // Dual enqueue across the wrap point
    commit2(32'h6000, 1'b1, 32'h6004, 1'b0);
    cyc();
    idle_commits();
    chk("wrap.count2", 64'(bus.count_o), 64'd2);
    cyc();
    chk_strobe("wrap.s0", 32'h6000, 1'b1);
    cyc();
    chk_strobe("wrap.s1", 32'h6004, 1'b0);
    chk("wrap.tail1", 64'(dut.tail_q), 64'd1);
    chk("wrap.head1", 64'(dut.head_q), 64'd1);

    // Simultaneous enqueue/dequeue at count 6
    bus.updateHold_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      commit2(32'h7000 + 32'(8 * k), 1'b0, 32'h7004 + 32'(8 * k), 1'b1);
      cyc();
    end
    chk("sim.count6", 64'(bus.count_o), 64'd6);
    chk("sim.full6", 64'(bus.full_o), 64'd0);
    bus.updateHold_i = 1'b0;
    commit2(32'h7018, 1'b0, 32'h701C, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cyc();
      idle_commits();
      chk_strobe($sformatf("sim%0d", k), 32'h7000 + 32'(4 * k), k[0]);
      chk($sformatf("sim%0d.count", k), 64'(bus.count_o), 64'(7 - k));
      if (k == 0) chk("sim.full7", 64'(bus.full_o), 64'd1);
    end
    cyc();
    chk("sim.en_off", 64'(bus.updateEn_o), 64'd0);

    // Reset in the middle of a drain
    bus.updateHold_i = 1'b1;
    commit2(32'h8000, 1'b1, 32'h8004, 1'b1);
    cyc();
    commit2(32'h8008, 1'b1, 32'h800C, 1'b1);
    cyc();
    idle_commits();
    bus.updateHold_i = 1'b0;
    cyc();
    chk_strobe("mid.s0", 32'h8000, 1'b1);
    chk("mid.count3", 64'(bus.count_o), 64'd3);
    #1 reset = 1'b1;
    #1;
    chk("mid.rst_en", 64'(bus.updateEn_o), 64'd0);
    chk("mid.rst_count", 64'(bus.count_o), 64'd0);
    chk("mid.rst_ovf", 64'(bus.overflow_o), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("post.en%0d", i), 64'(bus.updateEn_o), 64'd0);
      chk($sformatf("post.count%0d", i), 64'(bus.count_o), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
